// File: rtl/instr_cache.sv
// ---------------------------------------------------------------------------
// instr_cache
//   Direct-mapped, read-only instruction cache. It sits between the PC and
//   instruction memory. A hit returns the word in the same cycle. A miss
//   stalls the front end while a full 128-bit line is refilled. The block
//   also keeps hit and miss counters for performance reporting.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   is_input_valid, addr       fetch request (byte address, bits [1:0] unused)
//   dout, is_hit, cache_stall  combinational lookup result / pipeline hold
//   mem_req, mem_addr, mem_gnt refill request handshake (line aligned)
//   mem_rvalid, mem_rdata      refill response, whole line in one beat
//   hit_count, miss_count      free-running performance counters
// ---------------------------------------------------------------------------
module instr_cache #(
   parameter int NUM_LINES  = 16,
   parameter int LINE_WORDS = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       is_input_valid,
   input  logic [31:0]                addr,
   output logic [31:0]                dout,
   output logic                       is_hit,
   output logic                       cache_stall,
   output logic                       mem_req,
   output logic [31:0]                mem_addr,
   input  logic                       mem_gnt,
   input  logic                       mem_rvalid,
   input  logic [LINE_WORDS*32-1:0]   mem_rdata,
   output logic [31:0]                hit_count,
   output logic [31:0]                miss_count
);

   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = 28 - IDX_W;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} state_t;
   typedef logic [LINE_WORDS-1:0][31:0] line_t;

   state_t               state_q, state_d;
   logic [NUM_LINES-1:0] valid_q, valid_d;
   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   logic [TAG_W-1:0]     tag_d  [NUM_LINES];
   line_t                data_q [NUM_LINES];
   line_t                data_d [NUM_LINES];
   logic [TAG_W-1:0]     miss_tag_q, miss_tag_d;
   logic [IDX_W-1:0]     miss_idx_q, miss_idx_d;
   line_t                line_q, line_d;
   logic [31:0]          hit_count_q, hit_count_d;
   logic [31:0]          miss_count_q, miss_count_d;

   logic [TAG_W-1:0]     addr_tag;
   logic [IDX_W-1:0]     addr_idx;
   logic [1:0]           addr_wsel;
   logic                 lookup_hit;
   logic                 lookup_miss;
   logic                 addr_unused;

   assign addr_tag    = addr[31:4+IDX_W];
   assign addr_idx    = addr[3+IDX_W:4];
   assign addr_wsel   = addr[3:2];
   assign addr_unused = ^addr[1:0];

   // Lookup is only enabled in IDLE; every other state reports a stall.
   assign lookup_hit  = (state_q == IDLE) && is_input_valid && valid_q[addr_idx] &&
                        (tag_q[addr_idx] == addr_tag);
   assign lookup_miss = (state_q == IDLE) && is_input_valid && !lookup_hit;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (lookup_miss) state_d = REQ;
         REQ:     if (mem_gnt)     state_d = WAIT;
         WAIT:    if (mem_rvalid)  state_d = FILL;
         FILL:                     state_d = IDLE;
         default:                  state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      is_hit      = lookup_hit;
      dout        = lookup_hit ? data_q[addr_idx][addr_wsel] : 32'd0;
      cache_stall = (state_q != IDLE) || lookup_miss;
      mem_req     = (state_q == REQ);
   end

   assign mem_addr   = {miss_tag_q, miss_idx_q, 4'b0000};
   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;

   // ---------------- datapath next values ----------------
   always_comb begin
      valid_d      = valid_q;
      tag_d        = tag_q;
      data_d       = data_q;
      miss_tag_d   = miss_tag_q;
      miss_idx_d   = miss_idx_q;
      line_d       = line_q;
      hit_count_d  = hit_count_q + {31'd0, lookup_hit};
      miss_count_d = miss_count_q + {31'd0, lookup_miss};
      // Refill address is captured once; later addr changes are ignored.
      if (lookup_miss) begin
         miss_tag_d = addr_tag;
         miss_idx_d = addr_idx;
      end
      // Line is captured only in WAIT, so a stale response is dropped.
      if (state_q == WAIT && mem_rvalid) line_d = mem_rdata;
      if (state_q == FILL) begin
         valid_d[miss_idx_q] = 1'b1;
         tag_d[miss_idx_q]   = miss_tag_q;
         data_d[miss_idx_q]  = line_q;
      end
   end

   // Control state, valid bits and counters: reset clears them.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q      <= '0;
         hit_count_q  <= '0;
         miss_count_q <= '0;
      end else begin
         valid_q      <= valid_d;
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
      end
   end

   // Tag, data and miss-capture storage: no reset is needed. The valid bits
   // alone decide whether a line can be used.
   always_ff @(posedge clk) begin
      miss_tag_q <= miss_tag_d;
      miss_idx_q <= miss_idx_d;
      line_q     <= line_d;
      for (int i = 0; i < NUM_LINES; i++) begin
         tag_q[i]  <= tag_d[i];
         data_q[i] <= data_d[i];
      end
   end

endmodule
